conv_encoder_param: RTL



---
 rtl/viterbi_pkg.sv | 24 ++
 rtl/conv_encoder_param.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi chain: encoder FSM states, default code
// parameters (also used by the decoder branch-metric unit) and a parity helper.
package viterbi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    TAIL  = 2'd2,
    DRAIN = 2'd3
  } enc_state_t;

  localparam int VIT_K = 3;
  localparam int VIT_N = 2;
  // poly 0 = 111 in the low slice, poly 1 = 101 in the high slice
  localparam logic [VIT_N*VIT_K-1:0] VIT_G = {3'b101, 3'b111};

  // Widest window the parity helper covers; K must not exceed this.
  localparam int PARITY_W = 16;

  function automatic logic parity(input logic [PARITY_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/conv_encoder_param.sv
// Rate-1/N, constraint-length-K feed-forward convolutional encoder with
// optional zero-tail termination and a stallable output register.
module conv_encoder_param
  import viterbi_pkg::*;
#(
  parameter int              K         = VIT_K,
  parameter int              N         = VIT_N,
  parameter logic [N*K-1:0]  G         = VIT_G,
  parameter int              FRAME_LEN = 16,
  parameter int              TAIL_EN   = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_valid,
  input  logic         i_data,
  output logic         o_ready,
  output logic [N-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_last,
  output logic         o_busy
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int TW = $clog2(K);

  enc_state_t      state_q, state_d;
  logic [K-2:0]    sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [N-1:0]    data_q, data_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;

  logic            can_out;
  logic            fire;
  logic            in_bit;
  logic            last_fire;
  logic            start_take;
  logic [K-1:0]    win;
  logic [N-1:0]    sym;

  // The output slot is free when empty or being emptied this cycle.
  assign can_out = !valid_q || i_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tcnt_d     = tcnt_q;
    fire       = 1'b0;
    in_bit     = 1'b0;
    last_fire  = 1'b0;
    start_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          start_take = 1'b1;
          state_d    = DATA;
          cnt_d      = '0;
          tcnt_d     = '0;
        end
      end
      DATA: begin
        if (i_valid && can_out) begin
          fire   = 1'b1;
          in_bit = i_data;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(FRAME_LEN - 1)) begin
            if (TAIL_EN != 0) begin
              state_d = TAIL;
            end else begin
              state_d   = DRAIN;
              last_fire = 1'b1;
            end
          end
        end
      end
      TAIL: begin
        // Tail bits are zeros injected internally; only backpressure gates them.
        if (can_out) begin
          fire   = 1'b1;
          tcnt_d = tcnt_q + TW'(1);
          if (tcnt_q == TW'(K - 2)) begin
            state_d   = DRAIN;
            last_fire = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (valid_q && i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign win = {in_bit, sr_q};

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_poly
      assign sym[gi] = parity(PARITY_W'(G[gi*K +: K] & win));
    end
  endgenerate

  always_comb begin
    sr_d    = sr_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (start_take) begin
      sr_d = '0;
    end else if (fire) begin
      sr_d = win[K-1:1];
    end
    if (fire) begin
      data_d  = sym;
      valid_d = 1'b1;
      last_d  = last_fire;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign o_ready = (state_q == DATA) && can_out;
  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign o_busy  = (state_q != IDLE);

endmodule
